// File: rtl/rcu_pkg.sv
// Shared types and default widths for the receiver control unit.
`default_nettype none

package rcu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REKEY  = 2'd2
  } rcu_state_t;

  localparam int RCU_KEY_W  = 128;
  localparam int RCU_DATA_W = 129;

endpackage

`default_nettype wire

// File: rtl/rcu_fifo.sv
// Show-ahead FIFO with registered occupancy and sticky overflow on dropped pushes.
`default_nettype none

module rcu_fifo
  import rcu_pkg::*;
#(
  parameter int DATA_W = RCU_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         clear_ovf_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              ovf_q;

  logic do_push;
  logic do_pop;
  logic drop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when a pop frees the head slot.
    do_push = push_i & (~full_o | do_pop);
    drop    = push_i & full_o & ~do_pop;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clear_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/rcu_stream_rx.sv
// Receiver control unit: first word after reset/rekey is the key, later words
// are buffered data blocks drained through an r_ready/pop handshake.
`default_nettype none

module rcu_stream_rx
  import rcu_pkg::*;
#(
  parameter int KEY_W  = RCU_KEY_W,
  parameter int DATA_W = RCU_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        read,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        rekey,
  input  logic                        pop,
  input  logic                        clear_ovf,
  output logic [KEY_W-1:0]            key,
  output logic                        key_valid,
  output logic [DATA_W-1:0]           data,
  output logic                        r_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow
);

  rcu_state_t       state_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             push;
  logic             fifo_empty;
  logic             fifo_full;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read) begin
            key_q       <= data_in[KEY_W-1:0];
            key_valid_q <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          // Old key stays visible until the replacement word arrives.
          if (rekey) begin
            key_valid_q <= 1'b0;
            state_q     <= REKEY;
          end
        end
        REKEY: begin
          if (read) begin
            key_q       <= data_in[KEY_W-1:0];
            key_valid_q <= 1'b1;
            state_q     <= STREAM;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign push = read && (state_q == STREAM);

  rcu_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_i      (push),
    .pop_i       (pop),
    .clear_ovf_i (clear_ovf),
    .wdata_i     (data_in),
    .rdata_o     (data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign r_ready   = ~fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

`default_nettype wire

// File: doc/rcu_stream_rx.md
Name: rcu_stream_rx

Overview:
Parametrised receiver control unit for the crypto datapath front end. The first accepted word after reset, or after a rekey request, is loaded as the cipher key. Every following accepted word is a data block, buffered in a show-ahead FIFO. The FIFO drains to the AES core through an r_ready/pop handshake. Adds rekey, buffering, and overflow flagging.

Parameters:
KEY_W, 128, key width in bits; KEY_W <= DATA_W
DATA_W, 129, data word width (bit DATA_W-1 is the mode/encrypt-decrypt flag carried with the block)
DEPTH, 4, FIFO depth in words; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
read  in  1  data_in valid this cycle; sampled on the rising edge of clk
data_in  in  DATA_W  incoming word
rekey  in  1  single-cycle request: the next accepted word is a new key
pop  in  1  downstream consumes the head word
clear_ovf  in  1  clears the sticky overflow flag
key  out  KEY_W  current key
key_valid  out  1  key loaded and not superseded by a pending rekey
data  out  DATA_W  FIFO head word (show-ahead)
r_ready  out  1  FIFO non-empty
count  out  CNT_W  FIFO occupancy
overflow  out  1  sticky flag: a data word was dropped because the FIFO was full

Behaviour:
- Reset (async, n_rst=0) values:
  - state=IDLE, key=0, key_valid=0, data=0, r_ready=0, count=0, overflow=0.
  - FIFO pointers are zeroed and stored words are discarded.
  - Reset mid-stream aborts the stream immediately, with no drain.
- State machine (state type in the shared package):
  - IDLE: read=1 -> key<=data_in[KEY_W-1:0], key_valid<=1, go to STREAM. The word is not pushed to the FIFO. rekey is ignored.
  - STREAM: read=1 pushes data_in to the FIFO. rekey=1 -> go to REKEY and set key_valid<=0. key keeps its old value until it is replaced.
  - STREAM with rekey=1 and read=1 in the same cycle: the word is pushed as data, then the state moves to REKEY.
  - REKEY: read=1 -> load the new key, set key_valid<=1, go to STREAM. A further rekey while in REKEY has no effect.
  - The FIFO keeps draining in every state. pop works regardless of state.
- Latency and handshake:
  - A word pushed on edge N into an empty FIFO makes data and r_ready valid after edge N, i.e. before the next falling edge.
  - A key loaded on edge N is visible on key after edge N.
  - pop on edge N with r_ready=1 advances the head. The next word, or r_ready=0, appears after edge N.
  - pop with r_ready=0 is ignored. count never underflows.
- Boundary conditions:
  - Full FIFO, push without pop: the word is dropped, overflow<=1, count stays DEPTH.
  - Full FIFO, push and pop in the same cycle: both succeed, count unchanged, no overflow.
  - Empty FIFO, push and pop in the same cycle: the pop is ignored and the push succeeds (count=1).
  - Read and write pointers wrap modulo DEPTH.
  - Overflow clearing: clear_ovf=1 clears overflow. If clear_ovf and a new overflow occur in the same cycle, the set wins.
  - count is registered and equals the number of stored words after each edge.
  - data reads 0 when the FIFO is empty.

Decomposition:
- Package rcu_pkg:
  - rcu_state_t enum {IDLE, STREAM, REKEY}
  - default width constants RCU_KEY_W=128 and RCU_DATA_W=129
- Sub-module rcu_fifo:
  - parametrised DATA_W/DEPTH synchronous show-ahead FIFO with push, pop, full, empty, count
  - overflow dropping is handled inside rcu_fifo
- The top level holds the FSM and the key register.

Test Plan:
1. Reset, then read=1 with data_in=129'h000112233445566778899AABBCCDDEEFF -> after the edge: key=128'h00112233445566778899AABBCCDDEEFF, key_valid=1, r_ready=0, count=0.
2. Continue read with 129'h0A0B0C566D0F6F0A0C0E0E0F0A0B0D0E0, then 129'h04278b840fb44aaa757c1bf04acbe1a3e, with pop=0 -> data holds the first block, r_ready=1, count=2. pop on two edges -> data shows the second block, then r_ready=0, count=0.
3. DEPTH=4: push 5 words with no pop -> count=4, overflow=1, data = first word. Push and pop in the same cycle while full -> count stays 4, overflow unchanged. clear_ovf -> overflow=0.
4. rekey in STREAM with 2 words buffered -> key_valid=0 and key unchanged. Next read with 129'h0FFEEDDCCBBAA99887766554433221100 -> key=128'hFFEEDDCCBBAA99887766554433221100, key_valid=1, count still 2.
5. rekey and read in the same cycle in STREAM -> the word goes to the FIFO (count+1) and the state is REKEY. The following read loads the key.
6. Assert n_rst=0 mid-stream with count=3 -> asynchronously, before the next edge: r_ready=0, count=0, key=0, key_valid=0. After release, the first read loads a key.
